pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. It turns the ID-stage hazard flag, EX-stage branch resolution, multi-cycle MUL/MULHU occupancy and EBREAK/illegal decode into per-cycle enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers. It owns the halt sequence: drain the pipeline, then freeze. It also keeps a stall-cycle performance counter.

## Interface

Parameters:
- MUL_LAT, 3: total EX-stage cycles taken by MUL/MULHU; legal range 1..15.
- DRAIN_CYCLES, 3: cycles to empty EX/MEM/WB before halting; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- id_stall_flag  in  1  load-use hazard detected in ID.
- id_valid_inst  in  1  ID holds a valid, legal instruction.
- id_illegal  in  1  ID instruction is illegal; qualified by if_id_valid_inst.
- if_id_valid_inst  in  1  IF/ID slot is occupied.
- id_is_mul  in  1  ID alu_func is ALU_MUL or ALU_MULHU.
- id_is_ebreak  in  1  ID instruction is EBREAK.
- ex_take_branch  in  1  branch/jump in EX resolved taken.
- if_pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID valid on next edge.
- id_ex_en  out  1  ID/EX register load enable.
- id_ex_bubble  out  1  load NOP into ID/EX instead of ID contents.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- halted  out  1  core halted.
- halt_illegal  out  1  halt caused by an illegal instruction.
- ctrl_state  out  2  0=RUN, 1=MUL_BUSY, 2=DRAIN, 3=HALTED.
- stall_cycles  out  32  count of front-end stall cycles.

## Operation

- Registered state: ctrl_state, 4-bit cnt, halted, halt_illegal, stall_cycles. All other outputs are combinational from state and inputs.

**RUN.** Default outputs: if_pc_en=1, if_id_en=1, id_ex_en=1, everything else 0. Events are evaluated in this priority order:
1. **ex_take_branch:** if_id_flush=1 and id_ex_bubble=1. This kills the ID instruction and overrides any stall, mul or halt in ID. PC still loads. Stay in RUN.
2. **id_stall_flag:** if_pc_en=0, if_id_en=0, id_ex_bubble=1. Stay in RUN.
3. **Halt request** (if_id_valid_inst & (id_is_ebreak | id_illegal)):
   - Outputs: if_pc_en=0, if_id_en=0, id_ex_bubble=1.
   - Updates: halt_illegal<=id_illegal, cnt<=DRAIN_CYCLES, go to DRAIN.
4. **id_valid_inst & id_is_mul:** normal issue. If MUL_LAT>1, set cnt<=MUL_LAT-1 and go to MUL_BUSY. Otherwise stay in RUN.

**MUL_BUSY.**
- Outputs: if_pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1.
- ex_take_branch and id_stall_flag are ignored (EX holds the MUL).
- Each cycle cnt<=cnt-1. When cnt==1, next state is RUN.
- The MUL result is latched into EX/MEM on the first RUN cycle.

**DRAIN.**
- Outputs: if_pc_en=0, if_id_en=0, id_ex_bubble=1. All inputs are ignored.
- Each cycle cnt<=cnt-1. When cnt==1, next state is HALTED.

**HALTED.**
- Outputs: if_pc_en=0, if_id_en=0, id_ex_en=0, id_ex_bubble=1, ex_mem_bubble=1, halted=1.
- Exits only on reset.

**stall_cycles.** Increments by 1 each cycle where if_pc_en=0 and state is not HALTED. It wraps modulo 2^32 without saturating.

## Timing

- **Reset** (rst=0 at an edge):
  - Registers: ctrl_state=RUN, cnt=0, halted=0, halt_illegal=0, stall_cycles=0.
  - While rst=0, outputs are forced to: if_pc_en=0, if_id_en=0, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, ex_mem_bubble=1.
  - Reset mid-MUL_BUSY or mid-DRAIN aborts immediately. The first cycle after rst returns to 1 is RUN.
- **Load-use stall:** exactly one cycle per assertion of id_stall_flag. The controller adds no latency.
- **MUL issue:** the cycle after issue through the following MUL_LAT-1 cycles is frozen. Total EX occupancy is MUL_LAT cycles.
- **Halt:** the request cycle is followed by DRAIN_CYCLES cycles in DRAIN. halted rises DRAIN_CYCLES+1 cycles after the request cycle's edge.
- **Branch vs stall in the same cycle:** branch wins. No stall is counted, because if_pc_en=1.
- **Branch vs halt request in the same cycle:** branch wins. No halt occurs and halt_illegal is unchanged.
- **Illegal and ebreak together:** halt_illegal=1.

## Test plan

- **Reset:** hold rst=0 for 2 cycles with random inputs -> ctrl_state=0, halted=0, stall_cycles=0, id_ex_bubble=1. On release, RUN with if_pc_en=1.
- **Load-use:** id_stall_flag=1 for 1 cycle -> if_pc_en=0, if_id_en=0, id_ex_bubble=1 that cycle. stall_cycles goes 0->1, and RUN defaults return the next cycle.
- **MUL with MUL_LAT=3:** issue MUL -> ctrl_state=1 for 2 cycles with ex_mem_bubble=1, then RUN. stall_cycles=2. ex_take_branch pulsed during MUL_BUSY is ignored.
- **Branch priority:** ex_take_branch=1 together with id_stall_flag=1 and id_is_ebreak=1 -> if_id_flush=1, id_ex_bubble=1, if_pc_en=1. State stays RUN and stall_cycles is unchanged.
- **EBREAK halt with DRAIN_CYCLES=3:** valid ebreak in ID -> DRAIN for 3 cycles, then halted=1 with halt_illegal=0. Outputs stay frozen for 10+ further cycles, and stall_cycles stops counting.
- **Illegal halt with reset mid-drain:** illegal instruction enters DRAIN with halt_illegal=1. Assert rst=0 in the 2nd DRAIN cycle -> next cycle ctrl_state=0, halt_illegal=0, halted stays 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the 5-stage core pipeline and its sequencing controller.
// Core-side hazard/decode flags in one direction, stage enables/flushes and status back.
interface pipe_ctrl_if;
  logic        id_stall_flag;
  logic        id_valid_inst;
  logic        id_illegal;
  logic        if_id_valid_inst;
  logic        id_is_mul;
  logic        id_is_ebreak;
  logic        ex_take_branch;

  logic        if_pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        halted;
  logic        halt_illegal;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  // Pipeline side: raises hazard/decode flags, consumes stage controls.
  modport master (
    output id_stall_flag, id_valid_inst, id_illegal, if_id_valid_inst,
           id_is_mul, id_is_ebreak, ex_take_branch,
    input  if_pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_bubble, halted, halt_illegal, ctrl_state, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_stall_flag, id_valid_inst, id_illegal, if_id_valid_inst,
           id_is_mul, id_is_ebreak, ex_take_branch,
    output if_pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_bubble, halted, halt_illegal, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/flush/bubble from hazard, branch, MUL and halt events.
// Zero-latency combinational controls; stalls the front end itself, no upstream backpressure.
module pipe_ctrl #(
  parameter int MUL_LAT      = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        halted_q;
  logic        halt_illegal_q, halt_illegal_nxt;
  logic [31:0] stall_cnt;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble;
  logic halt_req;

  assign halt_req = bus.if_id_valid_inst & (bus.id_is_ebreak | bus.id_illegal);

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    halt_illegal_nxt = halt_illegal_q;
    pc_en            = 1'b1;
    ifid_en          = 1'b1;
    ifid_flush       = 1'b0;
    idex_en          = 1'b1;
    idex_bubble      = 1'b0;
    exmem_bubble     = 1'b0;

    case (state)
      S_RUN: begin
        // A taken branch kills whatever sits in ID, so it outranks every ID-side event.
        if (bus.ex_take_branch) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (bus.id_stall_flag) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (halt_req) begin
          pc_en            = 1'b0;
          ifid_en          = 1'b0;
          idex_bubble      = 1'b1;
          halt_illegal_nxt = bus.id_illegal;
          cnt_nxt          = 4'(DRAIN_CYCLES);
          state_nxt        = S_DRAIN;
        end else if (bus.id_valid_inst && bus.id_is_mul && (MUL_LAT > 1)) begin
          cnt_nxt   = 4'(MUL_LAT - 1);
          state_nxt = S_MUL_BUSY;
        end
      end
      S_MUL_BUSY: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
        cnt_nxt      = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RUN;
      end
      S_DRAIN: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        cnt_nxt     = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_RUN;
      cnt            <= 4'd0;
      halted_q       <= 1'b0;
      halt_illegal_q <= 1'b0;
      stall_cnt      <= 32'd0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      halted_q       <= (state_nxt == S_HALTED);
      halt_illegal_q <= halt_illegal_nxt;
      if (!pc_en && state != S_HALTED) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Reset holds the front end and injects NOPs regardless of the registered state.
  assign bus.if_pc_en      = rst & pc_en;
  assign bus.if_id_en      = rst & ifid_en;
  assign bus.if_id_flush   = ~rst | ifid_flush;
  assign bus.id_ex_en      = ~rst | idex_en;
  assign bus.id_ex_bubble  = ~rst | idex_bubble;
  assign bus.ex_mem_bubble = ~rst | exmem_bubble;
  assign bus.halted        = halted_q;
  assign bus.halt_illegal  = halt_illegal_q;
  assign bus.ctrl_state    = state;
  assign bus.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level behavioural model checked every negedge.
module tb_pipe_ctrl;
  localparam int MUL_LAT      = 3;
  localparam int DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MUL_LAT(MUL_LAT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errs   = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Model state: remaining frozen MUL cycles, remaining drain cycles, halt flags, stall count.
  int          m_mul_left   = 0;
  int          m_drain_left = 0;
  logic        m_halted     = 1'b0;
  logic        m_illegal    = 1'b0;
  logic [31:0] m_stalls     = 32'd0;

  typedef struct packed {
    logic pc, ifid, flush, idex, idbub, exbub;
  } ctl_t;

  function automatic int mode();
    if (m_halted)               return 3;
    else if (m_drain_left > 0)  return 2;
    else if (m_mul_left > 0)    return 1;
    else                        return 0;
  endfunction

  function automatic ctl_t exp_ctl();
    ctl_t c;
    c = '{pc:1'b1, ifid:1'b1, flush:1'b0, idex:1'b1, idbub:1'b0, exbub:1'b0};
    if (!rst) return '{pc:1'b0, ifid:1'b0, flush:1'b1, idex:1'b1, idbub:1'b1, exbub:1'b1};
    case (mode())
      0: begin
        if (bus.ex_take_branch) begin
          c.flush = 1'b1; c.idbub = 1'b1;
        end else if (bus.id_stall_flag ||
                     (bus.if_id_valid_inst && (bus.id_is_ebreak || bus.id_illegal))) begin
          c.pc = 1'b0; c.ifid = 1'b0; c.idbub = 1'b1;
        end
      end
      1: begin c.pc = 1'b0; c.ifid = 1'b0; c.idex = 1'b0; c.exbub = 1'b1; end
      2: begin c.pc = 1'b0; c.ifid = 1'b0; c.idbub = 1'b1; end
      default: begin
        c.pc = 1'b0; c.ifid = 1'b0; c.idex = 1'b0; c.idbub = 1'b1; c.exbub = 1'b1;
      end
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_step
    ctl_t c;
    int   md;
    c  = exp_ctl();
    md = mode();
    if (!rst) begin
      m_mul_left = 0; m_drain_left = 0; m_halted = 1'b0; m_illegal = 1'b0; m_stalls = 32'd0;
    end else begin
      if (!c.pc && md != 3) m_stalls = m_stalls + 32'd1;
      case (md)
        0: if (!bus.ex_take_branch && !bus.id_stall_flag) begin
             if (bus.if_id_valid_inst && (bus.id_is_ebreak || bus.id_illegal)) begin
               m_drain_left = DRAIN_CYCLES;
               m_illegal    = bus.id_illegal;
             end else if (bus.id_valid_inst && bus.id_is_mul) begin
               m_mul_left = MUL_LAT - 1;
             end
           end
        1: m_mul_left = m_mul_left - 1;
        2: begin
             m_drain_left = m_drain_left - 1;
             if (m_drain_left == 0) m_halted = 1'b1;
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    ctl_t c;
    if (chk_en) begin
      c = exp_ctl();
      chk("if_pc_en",      32'(bus.if_pc_en),      32'(c.pc));
      chk("if_id_en",      32'(bus.if_id_en),      32'(c.ifid));
      chk("if_id_flush",   32'(bus.if_id_flush),   32'(c.flush));
      chk("id_ex_en",      32'(bus.id_ex_en),      32'(c.idex));
      chk("id_ex_bubble",  32'(bus.id_ex_bubble),  32'(c.idbub));
      chk("ex_mem_bubble", 32'(bus.ex_mem_bubble), 32'(c.exbub));
      chk("ctrl_state",    32'(bus.ctrl_state),    32'(mode()));
      chk("halted",        32'(bus.halted),        32'(m_halted));
      chk("halt_illegal",  32'(bus.halt_illegal),  32'(m_illegal));
      chk("stall_cycles",  bus.stall_cycles,       m_stalls);
    end
  end

  // Inputs change 2 time units after the edge; literal checks follow 1 unit later.
  task automatic drive(input logic r, input logic st, input logic vi, input logic il,
                       input logic iv, input logic mu, input logic eb, input logic br);
    @(posedge clk);
    #2;
    rst                  = r;
    bus.id_stall_flag    = st;
    bus.id_valid_inst    = vi;
    bus.id_illegal       = il;
    bus.if_id_valid_inst = iv;
    bus.id_is_mul        = mu;
    bus.id_is_ebreak     = eb;
    bus.ex_take_branch   = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rnd(input logic r);
    drive(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b0;
    bus.id_stall_flag    = 1'b1;
    bus.id_valid_inst    = 1'b1;
    bus.id_illegal       = 1'b0;
    bus.if_id_valid_inst = 1'b1;
    bus.id_is_mul        = 1'b1;
    bus.id_is_ebreak     = 1'b1;
    bus.ex_take_branch   = 1'b0;

    // Reset with random inputs
    rnd(1'b0);
    chk_en = 1'b1;
    rnd(1'b0);
    chk("rst ctrl_state", 32'(bus.ctrl_state), 32'd0);
    chk("rst halted", 32'(bus.halted), 32'd0);
    chk("rst stall_cycles", bus.stall_cycles, 32'd0);
    chk("rst id_ex_bubble", 32'(bus.id_ex_bubble), 32'd1);
    chk("rst if_id_flush", 32'(bus.if_id_flush), 32'd1);
    idle();
    chk("release if_pc_en", 32'(bus.if_pc_en), 32'd1);

    // Load-use stall
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("loaduse if_pc_en", 32'(bus.if_pc_en), 32'd0);
    chk("loaduse id_ex_bubble", 32'(bus.id_ex_bubble), 32'd1);
    idle();
    chk("loaduse stall_cycles", bus.stall_cycles, 32'd1);
    chk("loaduse recover if_id_en", 32'(bus.if_id_en), 32'd1);

    // MUL issue, branch during busy ignored
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("mul state busy1", 32'(bus.ctrl_state), 32'd1);
    chk("mul ex_mem_bubble", 32'(bus.ex_mem_bubble), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mul state busy2", 32'(bus.ctrl_state), 32'd1);
    chk("mul branch ignored flush", 32'(bus.if_id_flush), 32'd0);
    idle();
    chk("mul back to run", 32'(bus.ctrl_state), 32'd0);
    chk("mul stall_cycles", bus.stall_cycles, 32'd3);

    // Branch beats stall and ebreak
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("br flush", 32'(bus.if_id_flush), 32'd1);
    chk("br bubble", 32'(bus.id_ex_bubble), 32'd1);
    chk("br pc_en", 32'(bus.if_pc_en), 32'd1);
    idle();
    chk("br state run", 32'(bus.ctrl_state), 32'd0);
    chk("br stall_cycles", bus.stall_cycles, 32'd3);

    // EBREAK halt
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ebreak req pc_en", 32'(bus.if_pc_en), 32'd0);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      idle();
      chk("ebreak drain state", 32'(bus.ctrl_state), 32'd2);
    end
    idle();
    chk("ebreak halted", 32'(bus.halted), 32'd1);
    chk("ebreak halt_illegal", 32'(bus.halt_illegal), 32'd0);
    for (int i = 0; i < 12; i++) rnd(1'b1);
    chk("halted frozen state", 32'(bus.ctrl_state), 32'd3);
    chk("halted stall frozen", bus.stall_cycles, 32'd7);

    // Reset out of HALTED
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("rehalt state run", 32'(bus.ctrl_state), 32'd0);
    chk("rehalt stall zero", bus.stall_cycles, 32'd0);

    // Illegal halt aborted by reset in the 2nd drain cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("illegal drain state", 32'(bus.ctrl_state), 32'd2);
    chk("illegal halt_illegal", 32'(bus.halt_illegal), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("abort state", 32'(bus.ctrl_state), 32'd0);
    chk("abort halt_illegal", 32'(bus.halt_illegal), 32'd0);
    chk("abort halted", 32'(bus.halted), 32'd0);

    // Illegal and ebreak together
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DRAIN_CYCLES + 1; i++) idle();
    chk("both halted", 32'(bus.halted), 32'd1);
    chk("both halt_illegal", 32'(bus.halt_illegal), 32'd1);
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
